// File: rtl/demux_pkg.sv
// Shared select codes and default widths for the 1-to-3 registered demultiplexer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package demux_pkg;

  // Destination select codes carried on Controle
  localparam logic [1:0] SEL_CANAL0   = 2'b00;
  localparam logic [1:0] SEL_CANAL1   = 2'b01;
  localparam logic [1:0] SEL_CANAL2   = 2'b10;
  localparam logic [1:0] SEL_INVALIDO = 2'b11;

  // Default data and counter widths
  localparam int LARGURA_PADRAO      = 8;
  localparam int LARGURA_CONT_PADRAO = 8;

endpackage

// File: rtl/demux3_8_reg_canal_saida.sv
// One output channel: single-entry buffer, valid flag and wrapping delivery counter.
// Latency: a load appears on dado_saida/valida one cycle after carga.
// Backpressure: pronto_para_carga drops while the entry is full and the sink is not ready.
module canal_saida #(
  parameter int LARGURA      = 8,
  parameter int LARGURA_CONT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    carga,
  input  logic [LARGURA-1:0]      dado,
  input  logic                    pronta,
  output logic [LARGURA-1:0]      dado_saida,
  output logic                    valida,
  output logic                    pronto_para_carga,
  output logic [LARGURA_CONT-1:0] contagem
);

  logic entrega;

  // A word leaves the buffer whenever it is held and the sink takes it
  assign entrega = valida && pronta;

  // The slot can take a new word if it is empty or being emptied this edge
  assign pronto_para_carga = !valida || pronta;

  // Buffer data: only a load changes it, so it holds under stall and after drain
  always_ff @(posedge clk) begin
    if (rst) begin
      dado_saida <= '0;
    end else if (carga) begin
      dado_saida <= dado;
    end
  end

  // Valid flag: a load wins over a simultaneous delivery so streaming stays at 1 word/cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      valida <= 1'b0;
    end else if (carga) begin
      valida <= 1'b1;
    end else if (entrega) begin
      valida <= 1'b0;
    end
  end

  // Delivery counter wraps naturally at its width
  always_ff @(posedge clk) begin
    if (rst) begin
      contagem <= '0;
    end else if (entrega) begin
      contagem <= contagem + 1'b1;
    end
  end

endmodule

// File: rtl/demux3_8_reg.sv
// Registered 1-to-3 demultiplexer: routes Entrada to one of three buffered channels by Controle.
// Latency: 1 cycle from input handshake to SaidaValida; drops flag ErroControle one cycle later.
// Backpressure: EntradaPronta is low only when the selected channel is full and its sink stalls.
module demux3_8_reg
  import demux_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int LARGURA_CONT = LARGURA_CONT_PADRAO
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [LARGURA-1:0]      Entrada,
  input  logic                    EntradaValida,
  output logic                    EntradaPronta,
  input  logic [1:0]              Controle,
  output logic [LARGURA-1:0]      Saida0,
  output logic [LARGURA-1:0]      Saida1,
  output logic [LARGURA-1:0]      Saida2,
  output logic [2:0]              SaidaValida,
  input  logic [2:0]              SaidaPronta,
  output logic [LARGURA_CONT-1:0] Contagem0,
  output logic [LARGURA_CONT-1:0] Contagem1,
  output logic [LARGURA_CONT-1:0] Contagem2,
  output logic [LARGURA_CONT-1:0] Descartes,
  output logic                    ErroControle
);

  logic [2:0] pronto_canal;
  logic [2:0] carga;
  logic       aceita;
  logic       descarte;

  // Ready toward the source follows the selected channel; invalid codes are always swallowed
  always_comb begin
    EntradaPronta = 1'b1;
    case (Controle)
      SEL_CANAL0: EntradaPronta = pronto_canal[0];
      SEL_CANAL1: EntradaPronta = pronto_canal[1];
      SEL_CANAL2: EntradaPronta = pronto_canal[2];
      default:    EntradaPronta = 1'b1;
    endcase
  end

  assign aceita = EntradaValida && EntradaPronta;

  // Decode an accepted word into a channel load or a discard
  always_comb begin
    carga    = 3'b000;
    descarte = 1'b0;
    if (aceita) begin
      case (Controle)
        SEL_CANAL0: carga[0] = 1'b1;
        SEL_CANAL1: carga[1] = 1'b1;
        SEL_CANAL2: carga[2] = 1'b1;
        default:    descarte = 1'b1;
      endcase
    end
  end

  canal_saida #(.LARGURA(LARGURA), .LARGURA_CONT(LARGURA_CONT)) u_canal0 (
    .clk               (Clock),
    .rst               (Reset),
    .carga             (carga[0]),
    .dado              (Entrada),
    .pronta            (SaidaPronta[0]),
    .dado_saida        (Saida0),
    .valida            (SaidaValida[0]),
    .pronto_para_carga (pronto_canal[0]),
    .contagem          (Contagem0)
  );

  canal_saida #(.LARGURA(LARGURA), .LARGURA_CONT(LARGURA_CONT)) u_canal1 (
    .clk               (Clock),
    .rst               (Reset),
    .carga             (carga[1]),
    .dado              (Entrada),
    .pronta            (SaidaPronta[1]),
    .dado_saida        (Saida1),
    .valida            (SaidaValida[1]),
    .pronto_para_carga (pronto_canal[1]),
    .contagem          (Contagem1)
  );

  canal_saida #(.LARGURA(LARGURA), .LARGURA_CONT(LARGURA_CONT)) u_canal2 (
    .clk               (Clock),
    .rst               (Reset),
    .carga             (carga[2]),
    .dado              (Entrada),
    .pronta            (SaidaPronta[2]),
    .dado_saida        (Saida2),
    .valida            (SaidaValida[2]),
    .pronto_para_carga (pronto_canal[2]),
    .contagem          (Contagem2)
  );

  // Discard counter saturates so a flood of bad selects never looks like zero
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Descartes <= '0;
    end else if (descarte && (Descartes != '1)) begin
      Descartes <= Descartes + 1'b1;
    end
  end

  // Error flag mirrors each drop for exactly the following cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ErroControle <= 1'b0;
    end else begin
      ErroControle <= descarte;
    end
  end

endmodule

// File: tb/tb_demux3_8_reg.sv
// Bench for demux3_8_reg: directed scenarios plus randomized traffic against a queue model.
// Latency: n/a.
// Backpressure: sink ready driven per channel by the scenarios.
module tb_demux3_8_reg;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Entrada = 8'h00;
  logic       EntradaValida = 1'b0;
  logic       EntradaPronta;
  logic [1:0] Controle = 2'b00;
  logic [7:0] Saida0, Saida1, Saida2;
  logic [2:0] SaidaValida;
  logic [2:0] SaidaPronta = 3'b000;
  logic [7:0] Contagem0, Contagem1, Contagem2;
  logic [7:0] Descartes;
  logic       ErroControle;

  int checks = 0;
  int failures = 0;

  demux3_8_reg dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Entrada       (Entrada),
    .EntradaValida (EntradaValida),
    .EntradaPronta (EntradaPronta),
    .Controle      (Controle),
    .Saida0        (Saida0),
    .Saida1        (Saida1),
    .Saida2        (Saida2),
    .SaidaValida   (SaidaValida),
    .SaidaPronta   (SaidaPronta),
    .Contagem0     (Contagem0),
    .Contagem1     (Contagem1),
    .Contagem2     (Contagem2),
    .Descartes     (Descartes),
    .ErroControle  (ErroControle)
  );

  always #5 Clock = ~Clock;

  // Reference model: each channel is a queue of at most one word; counts are plain integers
  logic [7:0] mq [3][$];
  logic [7:0] m_last [3] = '{8'h00, 8'h00, 8'h00};
  int         m_cnt [3] = '{0, 0, 0};
  int         m_desc = 0;
  bit         m_err = 1'b0;

  function automatic bit m_pronta();
    if (Controle == 2'd3) return 1'b1;
    return (mq[Controle].size() == 0) || SaidaPronta[Controle];
  endfunction

  function automatic logic [7:0] dut_saida(int n);
    case (n)
      0: return Saida0;
      1: return Saida1;
      default: return Saida2;
    endcase
  endfunction

  function automatic logic [7:0] dut_cont(int n);
    case (n)
      0: return Contagem0;
      1: return Contagem1;
      default: return Contagem2;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      for (int n = 0; n < 3; n++) begin
        mq[n].delete();
        m_last[n] = 8'h00;
        m_cnt[n] = 0;
      end
      m_desc = 0;
      m_err = 1'b0;
    end else begin
      bit acc;
      int c;
      c = int'(Controle);
      acc = EntradaValida && m_pronta();
      for (int n = 0; n < 3; n++) begin
        if (mq[n].size() > 0 && SaidaPronta[n]) begin
          void'(mq[n].pop_front());
          m_cnt[n] = m_cnt[n] + 1;
        end
      end
      if (acc && c != 3) begin
        mq[c].push_back(Entrada);
        m_last[c] = Entrada;
      end
      m_err = acc && (c == 3);
      if (m_err && m_desc < 255) m_desc = m_desc + 1;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    EntradaValida = 1'b0;
    SaidaPronta = 3'b000;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    EntradaValida = 1'b1;
    Entrada = 8'hFF;
    Controle = 2'b00;
    SaidaPronta = 3'b000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (SaidaValida !== 3'b000 || Saida0 !== 8'h00 || Saida1 !== 8'h00 || Saida2 !== 8'h00 ||
          Contagem0 !== 8'h00 || Contagem1 !== 8'h00 || Contagem2 !== 8'h00 ||
          Descartes !== 8'h00 || ErroControle !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got vld=%b s0=%h s1=%h s2=%h c=%h/%h/%h d=%h e=%b expected all zero",
                 i, SaidaValida, Saida0, Saida1, Saida2, Contagem0, Contagem1, Contagem2, Descartes, ErroControle);
      end
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (Saida0 !== 8'hFF || SaidaValida !== 3'b001) begin
      failures++;
      $display("FAIL reset_first_load got s0=%h vld=%b expected s0=ff vld=001", Saida0, SaidaValida);
    end
    EntradaValida = 1'b0;
    SaidaPronta = 3'b111;
    tick();
  endtask

  task automatic test_routing();
    logic [7:0] dat [3] = '{8'hFF, 8'h55, 8'h00};
    do_reset();
    SaidaPronta = 3'b111;
    EntradaValida = 1'b1;
    for (int n = 0; n < 3; n++) begin
      Entrada = dat[n];
      Controle = 2'(n);
      #1;
      checks++;
      if (EntradaPronta !== 1'b1) begin
        failures++;
        $display("FAIL routing_pronta ch=%0d got %b expected 1", n, EntradaPronta);
      end
      tick();
      checks++;
      if (SaidaValida !== 3'(1 << n) || dut_saida(n) !== dat[n]) begin
        failures++;
        $display("FAIL routing_load ch=%0d got vld=%b dat=%h expected vld=%b dat=%h",
                 n, SaidaValida, dut_saida(n), 3'(1 << n), dat[n]);
      end
    end
    EntradaValida = 1'b0;
    tick();
    checks++;
    if (SaidaValida !== 3'b000 || Contagem0 !== 8'd1 || Contagem1 !== 8'd1 || Contagem2 !== 8'd1) begin
      failures++;
      $display("FAIL routing_counts got vld=%b c=%0d/%0d/%0d expected vld=000 c=1/1/1",
               SaidaValida, Contagem0, Contagem1, Contagem2);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    SaidaPronta = 3'b101;
    EntradaValida = 1'b1;
    Entrada = 8'hA5;
    Controle = 2'b01;
    tick();
    Entrada = 8'h3C;
    #1;
    checks++;
    if (EntradaPronta !== 1'b0) begin
      failures++;
      $display("FAIL bp_pronta_low got %b expected 0", EntradaPronta);
    end
    tick();
    checks++;
    if (Saida1 !== 8'hA5 || SaidaValida[1] !== 1'b1 || Contagem1 !== 8'd0) begin
      failures++;
      $display("FAIL bp_hold got s1=%h vld1=%b c1=%0d expected a5 1 0", Saida1, SaidaValida[1], Contagem1);
    end
    SaidaPronta = 3'b111;
    #1;
    checks++;
    if (EntradaPronta !== 1'b1) begin
      failures++;
      $display("FAIL bp_pronta_high got %b expected 1", EntradaPronta);
    end
    tick();
    checks++;
    if (Saida1 !== 8'h3C || SaidaValida[1] !== 1'b1 || Contagem1 !== 8'd1) begin
      failures++;
      $display("FAIL bp_release got s1=%h vld1=%b c1=%0d expected 3c 1 1", Saida1, SaidaValida[1], Contagem1);
    end
    EntradaValida = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    int bad_pr = 0;
    int bad_out = 0;
    logic [7:0] w;
    do_reset();
    SaidaPronta = 3'b100;
    EntradaValida = 1'b1;
    Controle = 2'b10;
    for (int i = 0; i < 300; i++) begin
      w = 8'($urandom);
      Entrada = w;
      #1;
      if (EntradaPronta !== 1'b1) bad_pr++;
      tick();
      if (SaidaValida[2] !== 1'b1 || Saida2 !== w) bad_out++;
    end
    checks++;
    if (bad_pr != 0) begin
      failures++;
      $display("FAIL stream_pronta got %0d low cycles expected 0", bad_pr);
    end
    checks++;
    if (bad_out != 0) begin
      failures++;
      $display("FAIL stream_output got %0d bad cycles expected 0", bad_out);
    end
    checks++;
    if (Contagem2 !== 8'd43 || SaidaValida[2] !== 1'b1) begin
      failures++;
      $display("FAIL stream_wrap got c2=%0d vld2=%b expected 43 1", Contagem2, SaidaValida[2]);
    end
    EntradaValida = 1'b0;
    tick();
  endtask

  task automatic test_invalid();
    do_reset();
    EntradaValida = 1'b1;
    Entrada = 8'h9A;
    Controle = 2'b01;
    tick();
    EntradaValida = 1'b0;
    SaidaPronta = 3'b111;
    tick();
    EntradaValida = 1'b1;
    Entrada = 8'h77;
    Controle = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (EntradaPronta !== 1'b1) begin
        failures++;
        $display("FAIL inv_pronta cyc=%0d got %b expected 1", i, EntradaPronta);
      end
      tick();
      checks++;
      if (ErroControle !== 1'b1 || Descartes !== 8'(i + 1) || SaidaValida !== 3'b000 ||
          Saida0 !== 8'h00 || Saida1 !== 8'h9A || Saida2 !== 8'h00) begin
        failures++;
        $display("FAIL inv_drop cyc=%0d got e=%b d=%0d vld=%b s=%h/%h/%h expected 1 %0d 000 00/9a/00",
                 i, ErroControle, Descartes, SaidaValida, Saida0, Saida1, Saida2, i + 1);
      end
    end
    EntradaValida = 1'b0;
    tick();
    checks++;
    if (ErroControle !== 1'b0 || Descartes !== 8'd3) begin
      failures++;
      $display("FAIL inv_after got e=%b d=%0d expected 0 3", ErroControle, Descartes);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    EntradaValida = 1'b1;
    Controle = 2'b11;
    for (int i = 0; i < 258; i++) begin
      Entrada = 8'($urandom);
      tick();
    end
    checks++;
    if (Descartes !== 8'hFF || ErroControle !== 1'b1) begin
      failures++;
      $display("FAIL sat_descartes got d=%h e=%b expected ff 1", Descartes, ErroControle);
    end
    EntradaValida = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    SaidaPronta = 3'b000;
    EntradaValida = 1'b1;
    Entrada = 8'h11;
    Controle = 2'b00;
    tick();
    Entrada = 8'h22;
    Controle = 2'b10;
    tick();
    EntradaValida = 1'b0;
    checks++;
    if (SaidaValida !== 3'b101) begin
      failures++;
      $display("FAIL mid_setup got vld=%b expected 101", SaidaValida);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (SaidaValida !== 3'b000 || Saida0 !== 8'h00 || Saida2 !== 8'h00 ||
        Contagem0 !== 8'd0 || Contagem2 !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset got vld=%b s0=%h s2=%h c0=%0d c2=%0d expected all zero",
               SaidaValida, Saida0, Saida2, Contagem0, Contagem2);
    end
    SaidaPronta = 3'b111;
    tick();
    checks++;
    if (Contagem0 !== 8'd0 || Contagem1 !== 8'd0 || Contagem2 !== 8'd0) begin
      failures++;
      $display("FAIL mid_no_count got c=%0d/%0d/%0d expected 0/0/0", Contagem0, Contagem1, Contagem2);
    end
  endtask

  task automatic test_random();
    bit exp_pr;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      Reset = ($urandom_range(0, 99) == 0);
      EntradaValida = ($urandom_range(0, 3) != 0);
      Entrada = 8'($urandom);
      Controle = 2'($urandom_range(0, 3));
      SaidaPronta = 3'($urandom);
      #1;
      exp_pr = m_pronta();
      checks++;
      if (EntradaPronta !== exp_pr) begin
        failures++;
        $display("FAIL rnd_pronta cyc=%0d got %b expected %b", i, EntradaPronta, exp_pr);
      end
      tick();
      for (int n = 0; n < 3; n++) begin
        checks++;
        if (SaidaValida[n] !== (mq[n].size() != 0) || dut_saida(n) !== m_last[n] ||
            dut_cont(n) !== 8'(m_cnt[n])) begin
          failures++;
          $display("FAIL rnd_canal cyc=%0d ch=%0d got vld=%b dat=%h cnt=%0d expected vld=%b dat=%h cnt=%0d",
                   i, n, SaidaValida[n], dut_saida(n), dut_cont(n), mq[n].size() != 0, m_last[n], 8'(m_cnt[n]));
        end
      end
      checks++;
      if (Descartes !== 8'(m_desc) || ErroControle !== m_err) begin
        failures++;
        $display("FAIL rnd_descarte cyc=%0d got d=%0d e=%b expected d=%0d e=%b",
                 i, Descartes, ErroControle, m_desc, m_err);
      end
    end
    Reset = 1'b0;
    EntradaValida = 1'b0;
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_streaming();
    test_invalid();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
